tri_cmd_sequencer: RTL and testbench



---
 rtl/celery_pkg.sv | 19 +
 rtl/tri_cmd_sequencer.sv | 118 +++++++++++
 tb/tb_tri_cmd_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/celery_pkg.sv
// Shared rasterizer types: vertex payloads, RGB565 colours and command opcodes.
package celery_pkg;

  typedef logic [15:0] rgb565_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] z;
  } vertex_t;

  typedef enum logic [1:0] {
    CMD_VERTEX = 2'd0,
    CMD_CLEAR  = 2'd1,
    CMD_SYNC   = 2'd2,
    CMD_RSVD   = 2'd3
  } cmd_op_t;

endpackage

// File: rtl/tri_cmd_sequencer.sv
// Command front-end: gathers vertex triples into triangles for the rasterizer and
// serialises framebuffer clears and sync barriers against in-flight work.
module tri_cmd_sequencer
  import celery_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  cmd_op_t     cmd_op,
  input  vertex_t     cmd_vertex,
  input  rgb565_t     cmd_color,
  output vertex_t     v0,
  output vertex_t     v1,
  output vertex_t     v2,
  output logic        tri_valid,
  input  logic        tri_ready,
  input  logic        rast_busy,
  output logic        fb_clear,
  output rgb565_t     fb_clear_color,
  input  logic        fb_clearing,
  output logic        sync_done,
  output logic        busy,
  output logic [15:0] tri_count,
  output logic [7:0]  drop_count
);

  localparam logic [2:0] ST_COLLECT   = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_CLR_IDLE  = 3'd2;
  localparam logic [2:0] ST_CLR_PULSE = 3'd3;
  localparam logic [2:0] ST_CLR_GUARD = 3'd4;
  localparam logic [2:0] ST_CLR_WAIT  = 3'd5;
  localparam logic [2:0] ST_SYNC_WAIT = 3'd6;

  logic [2:0] state;
  logic [1:0] vtx_cnt;
  logic       rast_idle;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  assign rast_idle = !rast_busy && tri_ready;

  // Handshake outputs decode registered state only, so no input reaches them combinationally.
  assign cmd_ready = (state == ST_COLLECT);
  assign tri_valid = (state == ST_ISSUE);
  assign fb_clear  = (state == ST_CLR_PULSE);
  assign busy      = (state != ST_COLLECT) || (vtx_cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_COLLECT;
      vtx_cnt        <= 2'd0;
      v0             <= '0;
      v1             <= '0;
      v2             <= '0;
      fb_clear_color <= '0;
      sync_done      <= 1'b0;
      tri_count      <= 16'd0;
      drop_count     <= 8'd0;
    end else begin
      sync_done <= 1'b0;
      case (state)
        ST_COLLECT: begin
          if (cmd_valid) begin
            case (cmd_op)
              CMD_VERTEX: begin
                case (vtx_cnt)
                  2'd0:    v0 <= cmd_vertex;
                  2'd1:    v1 <= cmd_vertex;
                  default: v2 <= cmd_vertex;
                endcase
                if (vtx_cnt == 2'd2) begin
                  vtx_cnt <= 2'd0;
                  state   <= ST_ISSUE;
                end else begin
                  vtx_cnt <= vtx_cnt + 2'd1;
                end
              end
              CMD_CLEAR: begin
                // A clear invalidates any half-built triangle; those vertices count as dropped.
                fb_clear_color <= cmd_color;
                drop_count     <= sat_add8(drop_count, vtx_cnt);
                vtx_cnt        <= 2'd0;
                state          <= ST_CLR_IDLE;
              end
              CMD_SYNC: state <= ST_SYNC_WAIT;
              default:  drop_count <= sat_add8(drop_count, 2'd1);
            endcase
          end
        end
        ST_ISSUE: begin
          if (tri_ready) begin
            tri_count <= tri_count + 16'd1;
            state     <= ST_COLLECT;
          end
        end
        ST_CLR_IDLE:  if (rast_idle) state <= ST_CLR_PULSE;
        ST_CLR_PULSE: state <= ST_CLR_GUARD;
        // fb_clearing lags the strobe by a cycle, so it is not trusted until CLR_WAIT.
        ST_CLR_GUARD: state <= ST_CLR_WAIT;
        ST_CLR_WAIT:  if (!fb_clearing) state <= ST_COLLECT;
        ST_SYNC_WAIT: begin
          if (rast_idle && !fb_clearing) begin
            sync_done <= 1'b1;
            state     <= ST_COLLECT;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_cmd_sequencer.sv
// Bench for tri_cmd_sequencer: directed scenarios plus random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_tri_cmd_sequencer;
  import celery_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  cmd_op_t     cmd_op;
  vertex_t     cmd_vertex;
  rgb565_t     cmd_color;
  vertex_t     v0, v1, v2;
  logic        tri_valid, tri_ready, rast_busy, fb_clear;
  rgb565_t     fb_clear_color;
  logic        fb_clearing, sync_done, busy;
  logic [15:0] tri_count;
  logic [7:0]  drop_count;

  tri_cmd_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_vertex(cmd_vertex), .cmd_color(cmd_color), .v0(v0), .v1(v1), .v2(v2),
    .tri_valid(tri_valid), .tri_ready(tri_ready), .rast_busy(rast_busy), .fb_clear(fb_clear),
    .fb_clear_color(fb_clear_color), .fb_clearing(fb_clearing), .sync_done(sync_done),
    .busy(busy), .tri_count(tri_count), .drop_count(drop_count)
  );

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  // Values the next cycle will drive
  logic    d_rst = 1'b1, d_valid = 1'b0, d_ready = 1'b1, d_rbusy = 1'b0, d_fbc = 1'b0;
  cmd_op_t d_op = CMD_VERTEX;
  vertex_t d_vtx = '0;
  rgb565_t d_color = '0;

  // Behavioural model: what the block is doing, not how it encodes it
  localparam int M_FREE = 0, M_OFFER = 1, M_CLEAR = 2, M_SYNC = 3;
  int          m_mode = M_FREE;
  int          m_clr_t = -1;   // -1: waiting for idle rasterizer, 0: strobe cycle, then cycles since strobe
  int          m_cnt = 0;
  vertex_t     m_slot [3];
  rgb565_t     m_color = '0;
  logic [15:0] m_tri = '0;
  int          m_drop = 0;
  bit          m_sync = 0;
  bit          m_known = 0;
  bit          m_acc = 0;

  vertex_t va, vb, vc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
    end
  endtask

  task automatic compare();
    chk("cmd_ready", 64'(cmd_ready), 64'(m_mode == M_FREE));
    chk("tri_valid", 64'(tri_valid), 64'(m_mode == M_OFFER));
    chk("fb_clear", 64'(fb_clear), 64'(m_mode == M_CLEAR && m_clr_t == 0));
    chk("sync_done", 64'(sync_done), 64'(m_sync));
    chk("busy", 64'(busy), 64'(m_mode != M_FREE || m_cnt != 0));
    chk("tri_count", 64'(tri_count), 64'(m_tri));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("fb_clear_color", 64'(fb_clear_color), 64'(m_color));
    chk("v0", 64'(v0), 64'(m_slot[0]));
    chk("v1", 64'(v1), 64'(m_slot[1]));
    chk("v2", 64'(v2), 64'(m_slot[2]));
  endtask

  task automatic model_advance();
    m_acc  = 0;
    m_sync = 0;
    if (d_rst) begin
      m_mode = M_FREE; m_clr_t = -1; m_cnt = 0; m_color = '0; m_tri = '0; m_drop = 0;
      for (int i = 0; i < 3; i++) m_slot[i] = '0;
      m_known = 1;
    end else begin
      case (m_mode)
        M_FREE: if (d_valid) begin
          m_acc = 1;
          case (d_op)
            CMD_VERTEX: begin
              m_slot[2'(m_cnt)] = d_vtx;
              m_cnt++;
              if (m_cnt == 3) begin m_cnt = 0; m_mode = M_OFFER; end
            end
            CMD_CLEAR: begin
              m_color = d_color;
              m_drop  = (m_drop + m_cnt > 255) ? 255 : m_drop + m_cnt;
              m_cnt   = 0;
              m_mode  = M_CLEAR;
              m_clr_t = -1;
            end
            CMD_SYNC: m_mode = M_SYNC;
            default:  m_drop = (m_drop < 255) ? m_drop + 1 : 255;
          endcase
        end
        M_OFFER: if (d_ready) begin m_tri = m_tri + 16'd1; m_mode = M_FREE; end
        M_CLEAR: begin
          if (m_clr_t < 0) begin
            if (!d_rbusy && d_ready) m_clr_t = 0;
          end else if (m_clr_t < 2) begin
            m_clr_t++;
          end else if (!d_fbc) begin
            m_mode = M_FREE;
          end
        end
        default: if (!d_rbusy && d_ready && !d_fbc) begin m_sync = 1; m_mode = M_FREE; end
      endcase
    end
  endtask

  // One clock: check the state left by the last edge, then drive and predict the next one.
  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    if (m_known) compare();
    rst = d_rst; cmd_valid = d_valid; cmd_op = d_op; cmd_vertex = d_vtx; cmd_color = d_color;
    tri_ready = d_ready; rast_busy = d_rbusy; fb_clearing = d_fbc;
    model_advance();
  endtask

  task automatic send_cmd(input cmd_op_t op, input vertex_t vtx, input rgb565_t col);
    int n;
    n = 0;
    d_valid = 1'b1; d_op = op; d_vtx = vtx; d_color = col;
    do begin cyc(); n++; end while (!m_acc && n < 6000);
    d_valid = 1'b0;
    if (!m_acc) begin
      tests++; fails++;
      $display("FAIL send_timeout at cycle %0d: got no accept after %0d cycles, required accept", cyc_n, n);
    end
  endtask

  task automatic do_reset();
    d_rst = 1'b1; d_valid = 1'b0; d_ready = 1'b1; d_rbusy = 1'b0; d_fbc = 1'b0;
    cyc();
    d_rst = 1'b0;
    cyc();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pk, ret, syncs;
    bit busy_ok;
    logic [63:0] r;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = CMD_VERTEX; cmd_vertex = '0; cmd_color = '0;
    tri_ready = 1'b1; rast_busy = 1'b0; fb_clearing = 1'b0;
    va = '{x: 10'd10,  y: 10'd20,  z: 16'h1234};
    vb = '{x: 10'd300, y: 10'd5,   z: 16'hBEEF};
    vc = '{x: 10'd7,   y: 10'd999, z: 16'h0042};

    // Reset state
    do_reset();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_tri_valid", 64'(tri_valid), 64'(0));
    chk("rst_counts", 64'({tri_count, drop_count}), 64'(0));
    chk("rst_v0", 64'(v0), 64'(0));
    cyc();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));

    // Triangle with tri_ready held high
    d_ready = 1'b1;
    send_cmd(CMD_VERTEX, va, '0); send_cmd(CMD_VERTEX, vb, '0); send_cmd(CMD_VERTEX, vc, '0);
    cyc();
    chk("t1_tri_valid", 64'(tri_valid), 64'(1));
    chk("t1_v0", 64'(v0), 64'(va));
    chk("t1_v1", 64'(v1), 64'(vb));
    chk("t1_v2", 64'(v2), 64'(vc));
    cyc();
    chk("t1_tri_valid_low", 64'(tri_valid), 64'(0));
    chk("t1_tri_count", 64'(tri_count), 64'(1));
    chk("t1_cmd_ready", 64'(cmd_ready), 64'(1));

    // Back-pressure for 10 cycles
    d_ready = 1'b0;
    send_cmd(CMD_VERTEX, va, '0); send_cmd(CMD_VERTEX, vb, '0); send_cmd(CMD_VERTEX, vc, '0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      d_ready = (k >= 10);
      cyc();
      if (tri_valid) n++;
    end
    chk("t2_valid_cycles", 64'(n), 64'(11));
    chk("t2_tri_count", 64'(tri_count), 64'(2));

    // Clear with partial triangle while rasterizer busy
    do_reset();
    d_rbusy = 1'b1;
    send_cmd(CMD_VERTEX, va, '0); send_cmd(CMD_VERTEX, vb, '0);
    send_cmd(CMD_CLEAR, '0, 16'hF800);
    n = 0; pk = -1; ret = -1;
    for (int k = 0; k < 40; k++) begin
      d_rbusy = (k < 5);
      d_fbc   = (pk >= 0 && k > pk && k <= pk + 3);
      cyc();
      if (fb_clear) begin n++; pk = k; end
      if (cmd_ready && ret < 0) ret = k;
    end
    chk("t3_pulses", 64'(n), 64'(1));
    chk("t3_pulse_cycle", 64'(pk), 64'(6));
    chk("t3_return_cycle", 64'(ret), 64'(11));
    chk("t3_color", 64'(fb_clear_color), 64'(16'hF800));
    chk("t3_drop", 64'(drop_count), 64'(2));

    // Long fb_clearing after the strobe
    do_reset();
    send_cmd(CMD_CLEAR, '0, 16'h07E0);
    pk = -1; ret = -1; busy_ok = 1;
    for (int k = 0; k < 4300; k++) begin
      d_fbc = (pk >= 0 && k > pk && k <= pk + 4096);
      cyc();
      if (fb_clear) pk = k;
      if (cmd_ready && ret < 0) ret = k;
      if (ret < 0 && !busy) busy_ok = 0;
      if (ret >= 0) break;
    end
    d_fbc = 1'b0;
    chk("t4_pulse_cycle", 64'(pk), 64'(1));
    chk("t4_return_cycle", 64'(ret), 64'(4099));
    chk("t4_busy_held", 64'(busy_ok), 64'(1));

    // SYNC keeps the partial triangle
    do_reset();
    d_rbusy = 1'b1;
    send_cmd(CMD_VERTEX, va, '0);
    send_cmd(CMD_SYNC, '0, '0);
    syncs = 0; ret = -1;
    for (int k = 0; k < 20; k++) begin
      d_rbusy = (k < 3);
      cyc();
      if (sync_done) syncs++;
      if (cmd_ready && ret < 0) ret = k;
    end
    chk("t5_sync_pulses", 64'(syncs), 64'(1));
    chk("t5_return_cycle", 64'(ret), 64'(4));
    send_cmd(CMD_VERTEX, vb, '0); send_cmd(CMD_VERTEX, vc, '0);
    cyc();
    chk("t5_tri_valid", 64'(tri_valid), 64'(1));
    chk("t5_v0", 64'(v0), 64'(va));
    chk("t5_v2", 64'(v2), 64'(vc));
    for (int i = 0; i < 300; i++) send_cmd(CMD_RSVD, '0, '0);
    cyc();
    chk("t5_drop_sat", 64'(drop_count), 64'(255));

    // Reset during ISSUE
    do_reset();
    send_cmd(CMD_RSVD, '0, '0);
    send_cmd(CMD_VERTEX, va, '0); send_cmd(CMD_VERTEX, vb, '0); send_cmd(CMD_VERTEX, vc, '0);
    cyc(); cyc();
    d_ready = 1'b0;
    send_cmd(CMD_VERTEX, vc, '0); send_cmd(CMD_VERTEX, vb, '0); send_cmd(CMD_VERTEX, va, '0);
    cyc();
    chk("t6_in_issue", 64'(tri_valid), 64'(1));
    d_rst = 1'b1;
    cyc();
    d_rst = 1'b0; d_ready = 1'b1;
    cyc();
    chk("t6_tri_valid", 64'(tri_valid), 64'(0));
    chk("t6_tri_count", 64'(tri_count), 64'(0));
    chk("t6_drop_count", 64'(drop_count), 64'(0));
    cyc();
    chk("t6_cmd_ready", 64'(cmd_ready), 64'(1));

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      r = {$urandom(), $urandom()};
      d_vtx   = r[35:0];
      d_color = r[63:48];
      d_valid = ($urandom_range(0, 2) != 0);
      n = $urandom_range(0, 9);
      d_op    = (n == 6) ? CMD_CLEAR : (n == 7) ? CMD_SYNC : (n == 8) ? CMD_RSVD : CMD_VERTEX;
      d_ready = ($urandom_range(0, 3) != 0);
      d_rbusy = ($urandom_range(0, 3) == 0);
      d_fbc   = ($urandom_range(0, 4) == 0);
      d_rst   = ($urandom_range(0, 399) == 0);
      cyc();
    end
    d_rst = 1'b0; d_valid = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
